fpcvt_decoder: RTL and testbench
================================

# fpcvt_decoder

Sequential inverse of the FPCVT converter. Takes an 8-bit floating-point code (sign S, 3-bit exponent E, 4-bit significand F) and produces the 12-bit two's-complement value (-1)^S · F · 2^E. It sits on the output side of the FPCVT path so benches and display logic can recover a linear value from a stored code. Input and output each use a valid/ready handshake. Shifting is iterative, one bit per cycle, so latency depends on E.

## Interface
- No parameters; widths are fixed: D is 12 bits, E 3 bits, F 4 bits.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  S/E/F are valid this cycle.
- in_ready  output  1  block can accept a code; high only in IDLE.
- S  input  1  sign bit.
- E  input  3  exponent, 0..7.
- F  input  4  significand, 0..15.
- out_valid  output  1  D holds a completed result.
- out_ready  input  1  consumer accepts D this cycle.
- D  output  12  two's-complement result.

## Operation
- **Registers**
  - mag: 12 bits.
  - cnt: 3 bits.
  - sgn: 1 bit.
  - state: IDLE, SHIFT, NEG, DONE.
  - D register: 12 bits.
- **IDLE**
  - in_ready=1.
  - On in_valid=1, capture mag={8'b0,F}, cnt=E, sgn=S, and go to SHIFT.
  - If in_valid=0, hold.
- **SHIFT**
  - If cnt≠0: mag<=mag<<1 and cnt<=cnt-1; stay in SHIFT.
  - If cnt==0: go to NEG.
  - Overflow cannot occur; the maximum is 15·2^7=1920 < 2047.
- **NEG**
  - D<=sgn ? (~mag+1) : mag, computed at 12 bits with the carry dropped.
  - Go to DONE.
  - F=0 gives D=0 for either sign; -0 is not representable.
- **DONE**
  - out_valid=1.
  - D is held stable until out_ready=1, then go to IDLE.
  - out_valid and D must not change while out_ready=0.
- **Handshake and flow**
  - in_valid and S/E/F are ignored outside IDLE.
  - There is no back-to-back accept. Completing in DONE and accepting in IDLE take separate cycles.
- **Asynchronous reset, including mid-operation:** state=IDLE, mag=0, cnt=0, sgn=0, D=0x000.

## Timing
- **Reset values:** in_ready=1 (state is IDLE), out_valid=0, D=0x000.
- **Latency:** E+2 cycles from the accept edge to the cycle out_valid rises (E SHIFT cycles, one zero-count SHIFT cycle, NEG, then DONE visible).
  - E=0 gives out_valid on the 2nd edge after the accept edge.
- **Minimum initiation interval:** E+4 cycles, with out_ready held at 1.
- **DONE exit:** when out_ready is sampled high, out_valid falls and in_ready rises at the next edge.
- All outputs are registered or decoded from state only; there is no combinational path from input to output.

## Structure
- **Package fpcvt_pkg, shared with the encoder side:**
  - state enum (IDLE, SHIFT, NEG, DONE) on 2 bits;
  - constants DATA_W=12, EXP_W=3, SIG_W=4.
- **Sub-module fpcvt_shift_neg (combinational):** one-bit left shift of mag and the conditional two's-complement negate, instanced once.
- The top level holds the FSM, counter and handshake.

## Test plan
- **Minimum code:** reset, then S=0 E=0 F=1 with in_valid → D=0x001, out_valid 2 cycles after accept.
- **Maximum code:** S=0 E=7 F=15 → D=0x780 (1920), out_valid 9 cycles after accept; in_ready=0 throughout.
- **Negative value:** S=1 E=3 F=5 → D=0xFD8 (-40), 5-cycle latency.
- **Zero with sign set:** S=1 E=5 F=0 → D=0x000.
- **Backpressure:** out_ready=0 for 4 cycles in DONE → D and out_valid stable and in_ready=0; a new in_valid pulse during DONE is ignored; in_ready returns one cycle after out_ready=1.
- **Reset mid-operation:** assert rst_n=0 during SHIFT for E=6 → D=0x000, out_valid=0 and in_ready=1 immediately; the next code (S=1 E=0 F=15) decodes to D=0xFF1 (-15).

Source files
------------

// File: rtl/fpcvt_pkg.sv
// Shared definitions for the FPCVT encode/decode path: field widths,
// decoder FSM states and the fixed-width two's-complement negate.
package fpcvt_pkg;

    localparam int DATA_W = 12;
    localparam int EXP_W  = 3;
    localparam int SIG_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        NEG   = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Carry out of the MSB is dropped, so negating zero yields zero.
    function automatic logic [DATA_W-1:0] twos_neg(input logic [DATA_W-1:0] v);
        return ~v + DATA_W'(1);
    endfunction

endpackage

// File: rtl/fpcvt_decoder_if.sv
// Code-in / value-out handshake bundle for the FPCVT decoder.
interface fpcvt_decoder_if;
    import fpcvt_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              S;
    logic [EXP_W-1:0]  E;
    logic [SIG_W-1:0]  F;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] D;

    modport slave (
        input  in_valid, S, E, F, out_ready,
        output in_ready, out_valid, D
    );

    modport master (
        output in_valid, S, E, F, out_ready,
        input  in_ready, out_valid, D
    );
endinterface

// File: rtl/fpcvt_shift_neg.sv
// Datapath helper: one-bit left shift of the magnitude and sign-controlled
// two's-complement negate of the finished magnitude.
module fpcvt_shift_neg
    import fpcvt_pkg::*;
(
    input  logic [DATA_W-1:0] mag_i,
    input  logic              sgn_i,
    output logic [DATA_W-1:0] mag_shl_o,
    output logic [DATA_W-1:0] res_o
);

    assign mag_shl_o = {mag_i[DATA_W-2:0], 1'b0};
    assign res_o     = sgn_i ? twos_neg(mag_i) : mag_i;

endmodule

// File: rtl/fpcvt_decoder.sv
// Sequential FPCVT decoder: expands an S/E/F code into a 12-bit signed value,
// shifting one bit per cycle, with valid/ready on both sides.
module fpcvt_decoder
    import fpcvt_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    fpcvt_decoder_if.slave  bus
);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  mag_q,   mag_d;
    logic [EXP_W-1:0]   cnt_q,   cnt_d;
    logic               sgn_q,   sgn_d;
    logic [DATA_W-1:0]  d_q,     d_d;

    logic [DATA_W-1:0]  mag_shl;
    logic [DATA_W-1:0]  mag_res;

    fpcvt_shift_neg u_shift_neg (
        .mag_i     (mag_q),
        .sgn_i     (sgn_q),
        .mag_shl_o (mag_shl),
        .res_o     (mag_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mag_q   <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            d_q     <= d_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        d_d     = d_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mag_d   = {{(DATA_W-SIG_W){1'b0}}, bus.F};
                    cnt_d   = bus.E;
                    sgn_d   = bus.S;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // A zero count still costs one cycle here before negating.
                if (cnt_q != '0) begin
                    mag_d = mag_shl;
                    cnt_d = cnt_q - EXP_W'(1);
                end else begin
                    state_d = NEG;
                end
            end
            NEG: begin
                d_d     = mag_res;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.D         = d_q;

endmodule

// File: tb/tb_fpcvt_decoder.sv
// Scoreboard bench for fpcvt_decoder: directed corner codes, backpressure,
// mid-operation reset and randomized codes against an arithmetic model.
module tb_fpcvt_decoder;
    import fpcvt_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpcvt_decoder_if bus ();

    fpcvt_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [11:0] d;
        int          lat;
        int          acc;
        int          id;
    } exp_t;

    exp_t sb[$];
    int errors  = 0;
    int checks  = 0;
    int cyc     = 0;
    int txn_id  = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] model(input bit s, input int e, input int f);
        int v;
        v = f * (1 << e);
        if (s) v = -v;
        return v[11:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic send(input bit s, input int e, input int f);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("send_wait_in_ready", 32'(bus.in_ready), 32'd1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.S = s;
        bus.E = e[2:0];
        bus.F = f[3:0];
        @(posedge clk);
        #1;
        sb.push_back('{d: model(s, e, f), lat: e + 2, acc: cyc, id: txn_id});
        txn_id++;
        bus.in_valid = 1'b0;
        bus.S = 1'($urandom);
        bus.E = 3'($urandom);
        bus.F = 4'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() > 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            chk("drain_timeout_pending", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // out_ready driver
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                2:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: protocol checks every cycle, result compare on each handshake.
    initial begin
        logic        prev_ov, prev_ordy, prev_hs;
        logic [11:0] prev_d;
        exp_t        e;
        prev_ov = 0; prev_ordy = 0; prev_hs = 0; prev_d = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov = 0; prev_ordy = 0; prev_hs = 0;
            end else begin
                if (sb.size() > 0)
                    chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
                if (prev_hs) begin
                    chk("exit_out_valid", 32'(bus.out_valid), 32'd0);
                    chk("exit_in_ready", 32'(bus.in_ready), 32'd1);
                end
                if (prev_ov && !prev_ordy) begin
                    chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
                    chk("hold_D", 32'(bus.D), 32'(prev_d));
                end
                if (bus.out_valid && !prev_ov) begin
                    if (sb.size() == 0)
                        chk("spurious_out_valid", 32'(bus.out_valid), 32'd0);
                    else
                        chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 32'(bus.out_valid), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("D", 32'(bus.D), 32'(e.d));
                        $display("txn %0d: D=0x%03h expected=0x%03h", e.id, bus.D, e.d);
                    end
                end
                prev_ov   = bus.out_valid;
                prev_ordy = bus.out_ready;
                prev_d    = bus.D;
                prev_hs   = bus.out_valid && bus.out_ready;
            end
        end
    end

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.S = 1'b0;
        bus.E = '0;
        bus.F = '0;

        repeat (3) @(negedge clk);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_D", 32'(bus.D), 32'h000);
        rst_n = 1'b1;

        // Corner codes
        send(0, 0, 1);
        send(0, 7, 15);
        send(1, 3, 5);
        send(1, 5, 0);
        wait_drain();

        // Backpressure with an ignored in_valid pulse while DONE
        rdy_mode = 2;
        send(0, 4, 9);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reached_done", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b1;
        bus.S = 1'b1;
        bus.E = 3'd1;
        bus.F = 4'd3;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rdy_mode = 0;
        wait_drain();

        // Reset during SHIFT
        send(0, 6, 9);
        repeat (3) @(negedge clk);
        sb.delete();
        rst_n = 1'b0;
        #1;
        chk("midrst_D", 32'(bus.D), 32'h000);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(1, 0, 15);
        wait_drain();

        // Randomized codes with random consumer backpressure
        rdy_mode = 1;
        for (int i = 0; i < 40; i++)
            send(1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
        wait_drain();
        rdy_mode = 0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
